// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared constants for the FC core result path and the output collector.
//   FC_OUT_DEPTH  : number of FC output neurons (result entries)
//   FC_OUT_DATA_W : signed result word width
//   FC_OUT_ADDR_W : result index width, FC_OUT_DEPTH == 2**FC_OUT_ADDR_W
//   fc_out_state_e: collector FSM states
// ---------------------------------------------------------------------------
package fc_pkg;

    localparam int FC_OUT_DEPTH  = 128;
    localparam int FC_OUT_DATA_W = 32;
    localparam int FC_OUT_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } fc_out_state_e;

endpackage

// File: rtl/fc_argmax_tracker.sv
// ---------------------------------------------------------------------------
// fc_argmax_tracker
// Running signed maximum and its index over a stream of beats that arrive in
// ascending index order.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear max/argmax to 0 (new pass)
//   en_i           : a beat is consumed this cycle
//   first_i        : the consumed beat is index 0 (seeds the running max)
//   data_i         : signed value of the consumed beat
//   index_i        : index of the consumed beat
//   max_o          : running (final after the last beat) maximum value
//   argmax_o       : index of max_o
// ---------------------------------------------------------------------------
module fc_argmax_tracker
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_OUT_DATA_W,
    parameter int ADDR_W = FC_OUT_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic        [ADDR_W-1:0] index_i,
    output logic signed [DATA_W-1:0] max_o,
    output logic        [ADDR_W-1:0] argmax_o
);

    logic signed [DATA_W-1:0] max_q, max_d;
    logic        [ADDR_W-1:0] idx_q, idx_d;

    // Strictly-greater compare on an ascending stream keeps the lowest index
    // on ties.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (clr_i) begin
            max_d = '0;
            idx_d = '0;
        end else if (en_i && (first_i || (data_i > max_q))) begin
            max_d = data_i;
            idx_d = index_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            max_q <= '0;
            idx_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    assign max_o    = max_q;
    assign argmax_o = idx_q;

endmodule

// File: rtl/fc_output_collector.sv
// ---------------------------------------------------------------------------
// fc_output_collector
// Captures one FC pass of DEPTH signed results from the core's write port,
// then drains them in index order over a valid/ready stream while tracking
// the argmax.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   start_i               : arm for a new pass (restarts while collecting)
//   fc_done_i             : core finished; ends collection
//   wr_en_i/addr_i/data_i : result write port from the FC core
//   m_valid_o/m_ready_i   : drain stream handshake
//   m_data_o/m_index_o    : current beat value and index
//   m_last_o              : current beat is index DEPTH-1
//   busy_o                : collecting or draining
//   done_o                : pass complete, held until next start_i
//   missing_o             : some index was never written this pass
//   argmax_o/max_o        : classification result, valid while done_o
// ---------------------------------------------------------------------------
module fc_output_collector
    import fc_pkg::*;
#(
    parameter int DEPTH  = FC_OUT_DEPTH,
    parameter int DATA_W = FC_OUT_DATA_W,
    parameter int ADDR_W = FC_OUT_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     fc_done_i,
    input  logic                     wr_en_i,
    input  logic        [ADDR_W-1:0] wr_addr_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic signed [DATA_W-1:0] m_data_o,
    output logic        [ADDR_W-1:0] m_index_o,
    output logic                     m_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     missing_o,
    output logic        [ADDR_W-1:0] argmax_o,
    output logic signed [DATA_W-1:0] max_o
);

    fc_out_state_e            state_q, state_d;
    logic [DEPTH-1:0]         written_q, written_d;
    logic                     missing_q, missing_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];

    logic                     m_valid_q, m_valid_d;
    logic signed [DATA_W-1:0] m_data_q, m_data_d;
    logic        [ADDR_W-1:0] m_index_q, m_index_d;
    logic                     m_last_q, m_last_d;

    logic                     hs;
    logic                     arm;
    logic                     wr_acc;
    logic                     load;
    logic        [ADDR_W-1:0] rd_addr;

    // Control FSM, write acceptance and bitmap
    always_comb begin
        hs        = m_valid_q & m_ready_i;
        arm       = start_i && (state_q != DRAIN);
        // A restart in the same cycle drops the write.
        wr_acc    = (state_q == COLLECT) && wr_en_i && !start_i;
        state_d   = state_q;
        written_d = written_q;
        missing_d = missing_q;

        if (wr_acc) begin
            written_d[wr_addr_i] = 1'b1;
        end

        case (state_q)
            IDLE:    if (start_i) state_d = COLLECT;
            COLLECT: begin
                if (start_i) begin
                    state_d = COLLECT;
                end else if (fc_done_i) begin
                    state_d   = DRAIN;
                    // Includes a write landing in the fc_done_i cycle.
                    missing_d = ~&written_d;
                end
            end
            DRAIN:   if (hs && m_last_q) state_d = DONE;
            DONE:    if (start_i) state_d = COLLECT;
            default: state_d = IDLE;
        endcase

        if (arm) begin
            written_d = '0;
            missing_d = 1'b0;
        end
    end

    // Stream register: first beat is fetched on the first DRAIN cycle, later
    // beats on each non-final handshake. Unwritten entries read as 0.
    always_comb begin
        load      = (state_q == DRAIN) && (!m_valid_q || (hs && !m_last_q));
        rd_addr   = m_valid_q ? (m_index_q + ADDR_W'(1)) : '0;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_index_d = rd_addr;
            m_data_d  = written_q[rd_addr] ? mem_q[rd_addr] : '0;
            m_last_d  = (rd_addr == ADDR_W'(DEPTH - 1));
        end else if (hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            written_q <= '0;
            missing_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            written_q <= written_d;
            missing_q <= missing_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
        end
    end

    // Result storage; stale contents are masked by the bitmap.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    fc_argmax_tracker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_argmax (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (arm),
        .en_i     (hs),
        .first_i  (m_index_q == '0),
        .data_i   (m_data_q),
        .index_i  (m_index_q),
        .max_o    (max_o),
        .argmax_o (argmax_o)
    );

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_index_o = m_index_q;
    assign m_last_o  = m_last_q;
    assign busy_o    = (state_q == COLLECT) || (state_q == DRAIN);
    assign done_o    = (state_q == DONE);
    assign missing_o = missing_q;

endmodule

// File: tb/tb_fc_output_collector.sv
// ---------------------------------------------------------------------------
// tb_fc_output_collector
// Scoreboard bench: expected beats are queued when a pass ends and compared
// against every stream handshake.
// ---------------------------------------------------------------------------
module tb_fc_output_collector;
    import fc_pkg::*;

    localparam int DEPTH = FC_OUT_DEPTH;
    localparam int DW    = FC_OUT_DATA_W;
    localparam int AW    = FC_OUT_ADDR_W;

    logic                 clk       = 1'b0;
    logic                 rst_n_i   = 1'b0;
    logic                 start_i   = 1'b0;
    logic                 fc_done_i = 1'b0;
    logic                 wr_en_i   = 1'b0;
    logic        [AW-1:0] wr_addr_i = '0;
    logic signed [DW-1:0] wr_data_i = '0;
    logic                 m_ready_i = 1'b1;
    logic                 m_valid_o;
    logic signed [DW-1:0] m_data_o;
    logic        [AW-1:0] m_index_o;
    logic                 m_last_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 missing_o;
    logic        [AW-1:0] argmax_o;
    logic signed [DW-1:0] max_o;

    fc_output_collector dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .fc_done_i (fc_done_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_index_o (m_index_o),
        .m_last_o  (m_last_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .missing_o (missing_o),
        .argmax_o  (argmax_o),
        .max_o     (max_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;

    beat_t                exp_q[$];
    beat_t                mon_b;
    int                   total  = 0;
    int                   bad    = 0;
    int                   hs_cnt = 0;
    int                   model_mem[DEPTH];
    bit                   model_wr[DEPTH];
    bit                   mon_hold = 1'b0;
    logic signed [DW-1:0] prev_data;
    logic        [AW-1:0] prev_idx;
    int                   n;
    int                   m_idx, m_max;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream monitor: stability under backpressure and scoreboard compare.
    always @(negedge clk) begin
        if (mon_hold && rst_n_i) begin
            check("hold_valid", m_valid_o, 1);
            check("hold_data", m_data_o, prev_data);
            check("hold_index", m_index_o, prev_idx);
        end
        if (m_valid_o && m_ready_i) begin
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_b = exp_q.pop_front();
                check("beat_index", m_index_o, mon_b.idx);
                check("beat_data", m_data_o, mon_b.data);
                check("beat_last", m_last_o, mon_b.last);
            end
            hs_cnt++;
        end
        mon_hold  = m_valid_o && !m_ready_i;
        prev_data = m_data_o;
        prev_idx  = m_index_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) model_wr[k] = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(a);
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
        model_mem[a] = d;
        model_wr[a]  = 1'b1;
    endtask

    task automatic model_argmax(output int idx, output int mx);
        int v;
        idx = 0;
        mx  = 0;
        for (int k = 0; k < DEPTH; k++) begin
            v = model_wr[k] ? model_mem[k] : 0;
            if (k == 0 || v > mx) begin
                mx  = v;
                idx = k;
            end
        end
    endtask

    // fc_done pulse, optionally with a write in the same cycle; queue beats.
    task automatic end_collect(input bit with_wr, input int a, input int d);
        fc_done_i = 1'b1;
        if (with_wr) begin
            wr_en_i   = 1'b1;
            wr_addr_i = AW'(a);
            wr_data_i = d;
            model_mem[a] = d;
            model_wr[a]  = 1'b1;
        end
        exp_q.delete();
        hs_cnt = 0;
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back('{idx: k, data: (model_wr[k] ? model_mem[k] : 0),
                              last: (k == DEPTH - 1)});
        tick();
        fc_done_i = 1'b0;
        wr_en_i   = 1'b0;
    endtask

    task automatic run_drain(input bit bp, input bit poke, input int abort_at,
                             output int cyc);
        cyc = 0;
        while (1) begin
            m_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
            if (poke) begin
                if (cyc == 20) begin
                    start_i   = 1'b1;
                    wr_en_i   = 1'b1;
                    wr_addr_i = AW'(100);
                    wr_data_i = 999;
                end else begin
                    start_i = 1'b0;
                    wr_en_i = 1'b0;
                end
            end
            if (done_o) break;
            if (abort_at > 0 && hs_cnt >= abort_at) break;
            if (cyc >= 4000) begin
                check("drain_timeout", done_o, 1);
                break;
            end
        end
        start_i   = 1'b0;
        wr_en_i   = 1'b0;
        m_ready_i = 1'b1;
    endtask

    task automatic check_result(input string tag, input bit bp, input int cyc,
                                input int miss, input int amax, input int mx);
        if (!bp) check({tag, "_cycles"}, cyc, DEPTH + 1);
        check({tag, "_done"}, done_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_valid_low"}, m_valid_o, 0);
        check({tag, "_missing"}, missing_o, miss);
        check({tag, "_argmax"}, argmax_o, amax);
        check({tag, "_max"}, max_o, mx);
        check({tag, "_beats"}, hs_cnt, DEPTH);
        check({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, m_valid_o, 0);
        check({tag, "_data"}, m_data_o, 0);
        check({tag, "_index"}, m_index_o, 0);
        check({tag, "_last"}, m_last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_missing"}, missing_o, 0);
        check({tag, "_argmax"}, argmax_o, 0);
        check({tag, "_max"}, max_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n_i = 1'b1;
        tick();

        // Full ramp pass, ready held high
        start_pass();
        check("ramp_busy", busy_o, 1);
        for (int k = 0; k < DEPTH; k++) wr(k, k - 64);
        end_collect(1'b0, 0, 0);
        run_drain(1'b0, 1'b0, 0, n);
        check_result("ramp", 1'b0, n, 0, 127, 63);

        // Random data under random backpressure
        start_pass();
        for (int k = 0; k < DEPTH; k++) wr(k, int'($urandom));
        end_collect(1'b0, 0, 0);
        run_drain(1'b1, 1'b0, 0, n);
        model_argmax(m_idx, m_max);
        check_result("bp", 1'b1, n, 0, m_idx, m_max);

        // Even addresses only, addr 4 overwritten
        start_pass();
        for (int k = 0; k < DEPTH; k += 2) wr(k, k + 1);
        wr(4, 5);
        wr(4, -9);
        end_collect(1'b0, 0, 0);
        run_drain(1'b0, 1'b0, 0, n);
        check_result("miss", 1'b0, n, 1, 126, 127);

        // Ties among negatives
        start_pass();
        for (int k = 0; k < DEPTH; k++) wr(k, (k == 10 || k == 90) ? 7 : -100);
        end_collect(1'b0, 0, 0);
        run_drain(1'b0, 1'b0, 0, n);
        check_result("tie", 1'b0, n, 0, 10, 7);

        start_pass();
        for (int k = 0; k < DEPTH; k++) wr(k, -5);
        end_collect(1'b0, 0, 0);
        run_drain(1'b0, 1'b0, 0, n);
        check_result("flat", 1'b0, n, 0, 0, -5);

        // Restart in COLLECT with a colliding write, write on the fc_done
        // cycle, start/write pokes during DRAIN
        start_pass();
        for (int k = 0; k < DEPTH; k++) wr(k, 1000 + k);
        start_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(3);
        wr_data_i = 55;
        tick();
        start_i = 1'b0;
        wr_en_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) model_wr[k] = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) if (k != 3) wr(k, k);
        end_collect(1'b1, 127, 5000);
        run_drain(1'b0, 1'b1, 0, n);
        check_result("edge", 1'b0, n, 1, 127, 5000);
        wr_en_i   = 1'b1;
        wr_addr_i = AW'(5);
        wr_data_i = 77;
        tick();
        wr_en_i = 1'b0;
        check("done_wr_done", done_o, 1);
        check("done_wr_busy", busy_o, 0);

        // Reset in the middle of a drain
        start_pass();
        for (int k = 0; k < DEPTH; k += 2) wr(k, k);
        end_collect(1'b0, 0, 0);
        check("mid_missing_set", missing_o, 1);
        run_drain(1'b0, 1'b0, 50, n);
        rst_n_i = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        tick();
        rst_n_i = 1'b1;
        tick();
        start_pass();
        for (int k = 0; k < DEPTH; k++) wr(k, (k * 37) % 101 - 50);
        end_collect(1'b0, 0, 0);
        run_drain(1'b0, 1'b0, 0, n);
        model_argmax(m_idx, m_max);
        check_result("post", 1'b0, n, 0, m_idx, m_max);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_output_collector.md
Name: fc_output_collector

Overview:
Consumer end of the FC core's result write port (wren/addr/data). Captures the DEPTH signed results of one FC pass into a local register array and tracks which addresses were written. When the core signals done, it drains all results in address order over a valid/ready stream toward the PS/DMA side. While draining it computes the argmax (the classification result).

Parameters:
DEPTH, 128, number of FC output neurons / result entries
DATA_W, 32, result word width (signed two's complement)
ADDR_W, 7, address width; DEPTH must equal 2**ADDR_W

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse, arms the collector for a new pass
fc_done_i  in  1  FC core done pulse; ends collection
wr_en_i  in  1  result write strobe from FC core
wr_addr_i  in  ADDR_W  result index
wr_data_i  in  DATA_W  result value
m_valid_o  out  1  stream beat valid
m_ready_i  in  1  downstream ready
m_data_o  out  DATA_W  result value of current beat
m_index_o  out  ADDR_W  index of current beat
m_last_o  out  1  high on the beat with index DEPTH-1
busy_o  out  1  high in COLLECT or DRAIN
done_o  out  1  level; high in DONE until next start_i
missing_o  out  1  sticky; at least one index was never written this pass
argmax_o  out  ADDR_W  index of the largest signed result; valid while done_o=1
max_o  out  DATA_W  value at argmax_o; valid while done_o=1

Behaviour:
- Reset (async, rst_n_i=0) clears state to IDLE and the written bitmap. All outputs go to 0. Array contents are not reset; the bitmap masks them. Reset mid-pass abandons the pass.
- States:
  - IDLE: start_i -> COLLECT.
  - COLLECT: fc_done_i -> DRAIN. start_i -> COLLECT with the bitmap cleared (restart).
  - DRAIN: after the handshake on the last beat -> DONE.
  - DONE: start_i -> COLLECT.
- Entering COLLECT clears the bitmap, missing_o, argmax_o and max_o.
- Writes are accepted only in COLLECT, including the cycle fc_done_i is high. An accepted write stores wr_data_i at wr_addr_i and sets the bitmap bit; a repeated address overwrites. wr_en_i in any other state is ignored.
- start_i and wr_en_i in the same COLLECT cycle: the restart wins and the write is dropped.
- start_i is ignored in DRAIN.
- On the DRAIN transition, missing_o is set if any bitmap bit is 0. Unwritten entries are emitted as data 0.
- Drain stream:
  - m_valid_o rises the cycle after DRAIN is entered, with m_index_o=0.
  - m_data_o, m_index_o and m_last_o are registered and hold stable while m_valid_o=1 and m_ready_i=0.
  - Handshake = m_valid_o & m_ready_i; the index advances by 1 per handshake.
  - With m_ready_i held high, one beat per cycle; DEPTH beats take DEPTH cycles.
  - m_valid_o drops the cycle after the last handshake.
- Argmax is updated on each handshake using a signed compare, strictly greater. Ties keep the lowest index; beat 0 initialises the running max. The final values are registered on entry to DONE.
- done_o rises the cycle after the last handshake.
- Single write port, single registered read path. No arithmetic beyond the signed DATA_W compare and the ADDR_W counter; the counter wraps only by the last-beat terminal.

Decomposition:
- Shared package fc_pkg:
  - FC_OUT_DEPTH=128, FC_OUT_DATA_W=32, FC_OUT_ADDR_W=7 (also used by the fc core and the top).
  - State encoding constants: IDLE, COLLECT, DRAIN, DONE.
- One natural sub-module: fc_argmax_tracker (running signed max/index on a handshake strobe, clear input). The array, bitmap, FSM and stream register stay in the top module.

Test Plan:
- Full pass: start, write addr k -> data k-64 for k=0..127 in order, fc_done. With ready=1, 128 beats on consecutive cycles: data -64..63, m_last on index 127, argmax_o=127, max_o=63, missing_o=0, then done_o=1.
- Backpressure: toggle m_ready_i pseudo-randomly. Data and index never change while valid && !ready; the sequence is still 0..127 with no duplicates.
- Missing/overwrite: write only even addresses, write addr 4 twice (5 then -9). missing_o=1, odd beats=0, beat 4=-9.
- Ties/negatives: all entries -100 except idx 10 and 90 = 7. argmax_o=10, max_o=7. All entries -5 -> argmax_o=0.
- Edge timing: write addr 127 in the same cycle as fc_done_i -> accepted, beat 127 carries it. wr_en_i in DRAIN/DONE -> ignored. start_i during DRAIN -> ignored. start_i during COLLECT -> bitmap cleared.
- Reset mid-drain after 50 beats: all outputs 0 and state IDLE immediately. A new start plus a full pass produces correct results with no stale missing_o.
